// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and pixel type.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Counter-width versions of the decode points, so comparisons stay width-matched.
  localparam logic [CNT_W-1:0] H_LAST        = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST        = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END     = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END     = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters, sync decode, visible flag and frame counter for 640x480@60.
module vga_timing
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic [7:0]       o_frame_cnt,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_visible
);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [7:0]       r_frame_cnt;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Advance the raster position; the frame counter steps on the (799,524) -> (0,0) wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      if (w_v_last) begin
        r_v_cnt     <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Sync pulses are decoded from the raw counters; the top registers them.
  assign o_hsync_n   = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
  assign o_vsync_n   = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
  assign o_visible   = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/screensaver_top.sv
// VGA screensaver: timing plus one procedural image, all outputs registered together.
module screensaver_top
  import vga_pkg::*;
#(
  parameter int IMAGE_SELECT = 0  // 1 = Sierpinski fractal, anything else = checkerboard
) (
  input  logic       clk_25_175,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic [7:0]       w_frame_cnt;
  logic             w_hsync_n;
  logic             w_vsync_n;
  logic             w_visible;
  rgb444_t          w_pix;

  logic             r_hsync;
  logic             r_vsync;
  rgb444_t          r_rgb;

  vga_timing u_timing (
    .i_clk       (clk_25_175),
    .i_rst_n     (rst),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_frame_cnt (w_frame_cnt),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_visible   (w_visible)
  );

  generate
    if (IMAGE_SELECT == 1) begin : gen_fractal
      // Only the low 9 bits of x and of the scrolled y take part in the AND test,
      // so the mask keeps the 9-bit wrap of ys without a separate narrow adder.
      logic w_hit;
      assign w_hit = ((w_h_cnt & (w_v_cnt + {2'b00, w_frame_cnt})) & 10'h1FF) == 10'd0;
      assign w_pix = w_hit ? rgb444_t'{r: 4'hF, g: 4'h0, b: 4'hF} : rgb444_t'('0);
    end else begin : gen_checker
      // Bit 5 of the scrolled coordinates selects the 32x32 square colour.
      logic w_white;
      assign w_white = (((w_h_cnt + {2'b00, w_frame_cnt}) ^
                         (w_v_cnt + {2'b00, w_frame_cnt})) & 10'h020) == 10'd0;
      assign w_pix = w_white ? rgb444_t'{r: 4'hF, g: 4'hF, b: 4'hF} : rgb444_t'('0);
    end
  endgenerate

  // Register sync and colour in the same stage so all five outputs stay aligned.
  always_ff @(posedge clk_25_175 or negedge rst) begin
    if (!rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_hsync <= w_hsync_n;
      r_vsync <= w_vsync_n;
      r_rgb   <= w_visible ? w_pix : rgb444_t'('0);
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign r     = r_rgb.r;
  assign g     = r_rgb.g;
  assign b     = r_rgb.b;

endmodule

// File: tb/tb_screensaver_top.sv
// Directed bench for screensaver_top: both image variants run side by side.
module tb_screensaver_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hs0, vs0, hs1, vs1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  always #5 clk = ~clk;

  screensaver_top #(.IMAGE_SELECT(0)) u_chk (
    .clk_25_175 (clk), .rst (rst), .hsync (hs0), .vsync (vs0), .r (r0), .g (g0), .b (b0)
  );

  screensaver_top #(.IMAGE_SELECT(1)) u_frac (
    .clk_25_175 (clk), .rst (rst), .hsync (hs1), .vsync (vs1), .r (r1), .g (g1), .b (b1)
  );

  localparam int FRAME = 420000;
  localparam logic [27:0] RST_VAL = {14'h3000, 14'h3000};

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Rising edges since reset release; outputs seen after edge k show pixel index k-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic exp_hs(int c);
    int h;
    h = (c - 1) % 800;
    return !(h >= 656 && h < 752);
  endfunction

  function automatic logic exp_vs(int c);
    int v;
    v = ((c - 1) / 800) % 525;
    return !(v >= 490 && v < 492);
  endfunction

  function automatic logic is_blank(int c);
    int h, v;
    h = (c - 1) % 800;
    v = ((c - 1) / 800) % 525;
    return (h >= 640) || (v >= 480);
  endfunction

  // Continuous monitor: sync shape, blanking, X and edge timestamps.
  int   hs_nf, hs_fall0, hs_fall1, hs_rise0, vs_nf, vs_fall0, vs_rise0;
  int   sync_err = 0, blank_err = 0, x_err = 0, blank_samples = 0;
  logic prev_hs, prev_vs;

  always @(negedge clk) begin
    if (!rst) begin
      hs_nf <= 0; hs_fall0 <= 0; hs_fall1 <= 0; hs_rise0 <= 0;
      vs_nf <= 0; vs_fall0 <= 0; vs_rise0 <= 0;
      prev_hs <= 1'b1; prev_vs <= 1'b1;
    end else if (cyc > 0) begin
      if ($isunknown({hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1}))
        x_err <= x_err + 1;
      if (hs0 !== exp_hs(cyc) || hs1 !== exp_hs(cyc) ||
          vs0 !== exp_vs(cyc) || vs1 !== exp_vs(cyc))
        sync_err <= sync_err + 1;
      if (is_blank(cyc)) begin
        blank_samples <= blank_samples + 1;
        if ({r0, g0, b0, r1, g1, b1} !== 24'h0) blank_err <= blank_err + 1;
      end
      if (prev_hs && !hs0) begin
        if (hs_nf == 0) hs_fall0 <= cyc;
        if (hs_nf == 1) hs_fall1 <= cyc;
        hs_nf <= hs_nf + 1;
      end
      if (!prev_hs && hs0 && hs_rise0 == 0) hs_rise0 <= cyc;
      if (prev_vs && !vs0) begin
        if (vs_nf == 0) vs_fall0 <= cyc;
        vs_nf <= vs_nf + 1;
      end
      if (!prev_vs && vs0 && vs_rise0 == 0) vs_rise0 <= cyc;
      prev_hs <= hs0;
      prev_vs <= vs0;
    end
  end

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("goto", cyc, n);
  endtask

  task automatic pix(input string tag, input int x, input int y, input int f,
                     input logic [11:0] e0, input logic [11:0] e1);
    goto(f * FRAME + y * 800 + x + 1);
    check({tag, "_chk"},  {20'h0, r0, g0, b0}, {20'h0, e0});
    check({tag, "_frac"}, {20'h0, r1, g1, b1}, {20'h0, e1});
  endtask

  initial begin
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_hold", {4'h0, hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1}, {4'h0, RST_VAL});
    end
    rst = 1'b1;

    pix("f0_0_0",   0,  0, 0, 12'hFFF, 12'hF0F);
    pix("f0_32_0", 32,  0, 0, 12'h000, 12'hF0F);
    pix("f0_1_1",   1,  1, 0, 12'hFFF, 12'h000);
    pix("f0_2_1",   2,  1, 0, 12'hFFF, 12'hF0F);
    goto(1600);
    check("hs_first_fall", hs_fall0, 657);
    check("hs_low_len",    hs_rise0 - hs_fall0, 96);
    check("hs_period",     hs_fall1 - hs_fall0, 800);
    pix("f0_32_32", 32, 32, 0, 12'hFFF, 12'h000);

    // Reset in the middle of a white checkerboard square.
    pix("pre_rst", 300, 100, 0, 12'hFFF, 12'h000);
    #2 rst = 1'b0;
    #1 check("async_rst", {4'h0, hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1}, {4'h0, RST_VAL});
    repeat (3) @(negedge clk);
    check("rst_held", {4'h0, hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1}, {4'h0, RST_VAL});
    rst = 1'b1;

    pix("rel_0_0",   0, 0, 0, 12'hFFF, 12'hF0F);
    pix("h639",    639, 0, 0, 12'h000, 12'hF0F);
    pix("h640",    640, 0, 0, 12'h000, 12'h000);
    goto(1600);
    check("rel_hs_first_fall", hs_fall0, 657);
    check("rel_hs_period",     hs_fall1 - hs_fall0, 800);
    pix("v479", 0, 479, 0, 12'hFFF, 12'hF0F);
    pix("v480", 0, 480, 0, 12'h000, 12'h000);
    goto(393700);
    check("vs_first_fall", vs_fall0, 392001);
    check("vs_low_len",    vs_rise0 - vs_fall0, 1600);

    pix("f1_0_0",    0,  0, 1, 12'hFFF, 12'hF0F);
    pix("f1_2_0",    2,  0, 1, 12'hFFF, 12'hF0F);
    pix("f1_31_0",  31,  0, 1, 12'h000, 12'h000);
    pix("f1_31_31", 31, 31, 1, 12'hFFF, 12'hF0F);

    check("sync_shape_errs", sync_err, 0);
    check("blank_errs",      blank_err, 0);
    check("x_errs",          x_err, 0);
    check("blank_seen",      {31'h0, blank_samples != 0}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
